// File: rtl/multdiv_param.sv
// multdiv_param -- sequential multiply/divide unit.
//
// Multiply: radix-4 Booth recoding of operand B, one digit per clock, so the
// result is ready WIDTH_B/2 cycles after the accept edge. Unsigned operands
// whose B has its top bit set get one extra A<<WIDTH_B term folded into the
// last Booth step, which keeps the latency unchanged.
// Divide: restoring iteration on magnitudes, one quotient bit per clock, plus
// one final cycle for sign correction and special cases (WIDTH_A+1 cycles).
//
// Optional feature macro: MULTDIV_REMAINDER_EN
//   defined   -> data_remainder carries the signed division remainder
//   undefined -> data_remainder is tied to zero and no remainder output
//                register is built
//
// Ports:
//   clock           single rising-edge clock
//   ctrl_reset_n    asynchronous active-low reset
//   data_operandA   operand A (dividend / multiplicand), sampled at accept
//   data_operandB   operand B (divisor / multiplier), sampled at accept
//   ctrl_MULT       multiply request (wins when both requests are high)
//   ctrl_DIV        divide request
//   ctrl_signed     1 = two's-complement operands, sampled at accept
//   data_result     product low bits or quotient
//   data_remainder  division remainder (zero for multiply)
//   data_exception  overflow / divide-by-zero flag for the held result
//   data_inputRDY   unit accepts a request on the coming edge
//   data_resultRDY  result outputs are valid and held
module multdiv_param #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_B = 16
) (
  input  logic               clock,
  input  logic               ctrl_reset_n,
  input  logic [WIDTH_A-1:0] data_operandA,
  input  logic [WIDTH_B-1:0] data_operandB,
  input  logic               ctrl_MULT,
  input  logic               ctrl_DIV,
  input  logic               ctrl_signed,
  output logic [WIDTH_A-1:0] data_result,
  output logic [WIDTH_B-1:0] data_remainder,
  output logic               data_exception,
  output logic               data_inputRDY,
  output logic               data_resultRDY
);

  // Product accumulator is wide enough for the full signed or unsigned
  // product plus the transient value before the unsigned correction term.
  localparam int PW = WIDTH_A + WIDTH_B + 2;
  localparam int CW = $clog2(WIDTH_A + 2);

  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH_B / 2 - 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(WIDTH_A);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      cnt_r;
  logic               input_rdy_r;
  logic               input_rdy_s;
  logic               accept_s;

  // Operation context latched at accept
  logic               signed_r;
  logic [WIDTH_B-1:0] b_r;          // Booth shifter (mult) or divisor magnitude (div)
  logic               b_msb_r;
  logic               booth_lsb_r;
  logic [PW-1:0]      mcand_r;
  logic [PW-1:0]      prod_r;
  logic [WIDTH_A-1:0] quo_r;
  logic [WIDTH_B-1:0] rem_r;
  logic               div_zero_r;
  logic               div_ovf_r;
  logic               neg_q_r;

  // Output registers
  logic [WIDTH_A-1:0] result_r;
  logic               exception_r;
  logic               result_rdy_r;

  // Accept-time operand preprocessing
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH_A-1:0] a_mag_s;
  logic [WIDTH_B-1:0] b_mag_s;
  logic [PW-1:0]      a_ext_s;
  logic               div_zero_s;
  logic               div_ovf_s;

  // Booth step
  logic [PW-1:0]      mcand2_s;
  logic [PW-1:0]      pp_s;
  logic [PW-1:0]      corr_s;
  logic [PW-1:0]      prod_next_s;
  logic               mult_ovf_s;

  // Restoring division step
  logic [WIDTH_B:0]   rem_shift_s;
  logic               div_ge_s;
  logic [WIDTH_B-1:0] rem_sub_s;
  logic [WIDTH_B-1:0] rem_next_s;
  logic [WIDTH_A-1:0] quo_next_s;
  logic [WIDTH_A-1:0] quo_final_s;

`ifdef MULTDIV_REMAINDER_EN
  logic               neg_r_r;
  logic [WIDTH_B-1:0] remainder_r;
  logic [WIDTH_B-1:0] rem_final_s;
`endif

  assign accept_s = input_rdy_r & (ctrl_MULT | ctrl_DIV);

  // FSM state register
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          if (ctrl_MULT) begin
            state_next_s = ST_MULT;
          end else begin
            state_next_s = ST_DIV;
          end
        end else begin
          state_next_s = state_r;
        end
      end
      ST_MULT: begin
        if (cnt_r == MULT_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_MULT;
        end
      end
      ST_DIV: begin
        if (cnt_r == DIV_LAST) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DIV;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output logic: ready for the state being entered, registered below
  always_comb begin
    input_rdy_s = 1'b0;
    case (state_next_s)
      ST_IDLE, ST_DONE: input_rdy_s = 1'b1;
      ST_MULT, ST_DIV:  input_rdy_s = 1'b0;
      default:          input_rdy_s = 1'b0;
    endcase
  end

  // Registered input-ready flag and iteration counter
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      input_rdy_r <= 1'b1;
      cnt_r       <= CNT_ZERO;
    end else begin
      input_rdy_r <= input_rdy_s;
      if (accept_s) begin
        cnt_r <= CNT_ZERO;
      end else if ((state_r == ST_MULT) || (state_r == ST_DIV)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Operand sign handling and divide special-case detection at accept
  always_comb begin
    a_neg_s    = ctrl_signed & data_operandA[WIDTH_A-1];
    b_neg_s    = ctrl_signed & data_operandB[WIDTH_B-1];
    a_mag_s    = a_neg_s ? ({WIDTH_A{1'b0}} - data_operandA) : data_operandA;
    b_mag_s    = b_neg_s ? ({WIDTH_B{1'b0}} - data_operandB) : data_operandB;
    a_ext_s    = {{(PW-WIDTH_A){a_neg_s}}, data_operandA};
    div_zero_s = (data_operandB == {WIDTH_B{1'b0}});
    div_ovf_s  = ctrl_signed
               & (data_operandA == {1'b1, {(WIDTH_A-1){1'b0}}})
               & (data_operandB == {WIDTH_B{1'b1}});
  end

  // Radix-4 Booth step; digit from {b[2i+1], b[2i], b[2i-1]}
  always_comb begin
    mcand2_s = mcand_r << 1'b1;
    pp_s     = {PW{1'b0}};
    case ({b_r[1:0], booth_lsb_r})
      3'b001, 3'b010: pp_s = mcand_r;
      3'b011:         pp_s = mcand2_s;
      3'b100:         pp_s = {PW{1'b0}} - mcand2_s;
      3'b101, 3'b110: pp_s = {PW{1'b0}} - mcand_r;
      default:        pp_s = {PW{1'b0}};
    endcase
    // The Booth digits treat B as signed; an unsigned B with its MSB set is
    // short by A * 2^WIDTH_B, i.e. the last step's multiplicand shifted by 2.
    if ((cnt_r == MULT_LAST) && !signed_r && b_msb_r) begin
      corr_s = mcand_r << 2'd2;
    end else begin
      corr_s = {PW{1'b0}};
    end
    prod_next_s = prod_r + pp_s + corr_s;
    if (signed_r) begin
      mult_ovf_s = ~((&prod_next_s[PW-1:WIDTH_A-1]) | ~(|prod_next_s[PW-1:WIDTH_A-1]));
    end else begin
      mult_ovf_s = |prod_next_s[PW-1:WIDTH_A];
    end
  end

  // Restoring division step and final sign correction
  always_comb begin
    rem_shift_s = {rem_r, quo_r[WIDTH_A-1]};
    div_ge_s    = (rem_shift_s >= {1'b0, b_r});
    // When the trial subtraction succeeds the true difference is below the
    // divisor, so the low WIDTH_B bits of the wrapped subtraction are exact.
    rem_sub_s   = rem_shift_s[WIDTH_B-1:0] - b_r;
    rem_next_s  = div_ge_s ? rem_sub_s : rem_shift_s[WIDTH_B-1:0];
    quo_next_s  = {quo_r[WIDTH_A-2:0], div_ge_s};
    if (div_zero_r) begin
      quo_final_s = {WIDTH_A{1'b0}};
    end else if (neg_q_r) begin
      quo_final_s = {WIDTH_A{1'b0}} - quo_r;
    end else begin
      quo_final_s = quo_r;
    end
`ifdef MULTDIV_REMAINDER_EN
    if (div_zero_r) begin
      rem_final_s = {WIDTH_B{1'b0}};
    end else if (neg_r_r) begin
      rem_final_s = {WIDTH_B{1'b0}} - rem_r;
    end else begin
      rem_final_s = rem_r;
    end
`endif
  end

  // Datapath: operand capture, iteration and result holding
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      signed_r     <= 1'b0;
      b_r          <= {WIDTH_B{1'b0}};
      b_msb_r      <= 1'b0;
      booth_lsb_r  <= 1'b0;
      mcand_r      <= {PW{1'b0}};
      prod_r       <= {PW{1'b0}};
      quo_r        <= {WIDTH_A{1'b0}};
      rem_r        <= {WIDTH_B{1'b0}};
      div_zero_r   <= 1'b0;
      div_ovf_r    <= 1'b0;
      neg_q_r      <= 1'b0;
      result_r     <= {WIDTH_A{1'b0}};
      exception_r  <= 1'b0;
      result_rdy_r <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      neg_r_r      <= 1'b0;
      remainder_r  <= {WIDTH_B{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            result_rdy_r <= 1'b0;
            signed_r     <= ctrl_signed;
            if (ctrl_MULT) begin
              mcand_r     <= a_ext_s;
              prod_r      <= {PW{1'b0}};
              b_r         <= data_operandB;
              b_msb_r     <= data_operandB[WIDTH_B-1];
              booth_lsb_r <= 1'b0;
            end else begin
              quo_r      <= a_mag_s;
              rem_r      <= {WIDTH_B{1'b0}};
              b_r        <= b_mag_s;
              div_zero_r <= div_zero_s;
              div_ovf_r  <= div_ovf_s;
              neg_q_r    <= a_neg_s ^ b_neg_s;
`ifdef MULTDIV_REMAINDER_EN
              neg_r_r    <= a_neg_s;
`endif
            end
          end
        end
        ST_MULT: begin
          prod_r      <= prod_next_s;
          mcand_r     <= mcand_r << 2'd2;
          b_r         <= {2'b00, b_r[WIDTH_B-1:2]};
          booth_lsb_r <= b_r[1];
          if (cnt_r == MULT_LAST) begin
            result_r     <= prod_next_s[WIDTH_A-1:0];
            exception_r  <= mult_ovf_s;
            result_rdy_r <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            remainder_r  <= {WIDTH_B{1'b0}};
`endif
          end
        end
        ST_DIV: begin
          if (cnt_r == DIV_LAST) begin
            result_r     <= quo_final_s;
            exception_r  <= div_zero_r | div_ovf_r;
            result_rdy_r <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
            remainder_r  <= rem_final_s;
`endif
          end else begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
          end
        end
        default: begin
          result_rdy_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = result_r;
  assign data_exception = exception_r;
  assign data_inputRDY  = input_rdy_r;
  assign data_resultRDY = result_rdy_r;

`ifdef MULTDIV_REMAINDER_EN
  assign data_remainder = remainder_r;
`else
  assign data_remainder = {WIDTH_B{1'b0}};
`endif

endmodule

// File: tb/tb_multdiv_param.sv
module tb_multdiv_param;

  logic        clock;
  logic        ctrl_reset_n;
  logic [31:0] data_operandA;
  logic [15:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        ctrl_signed;
  logic [31:0] data_result;
  logic [15:0] data_remainder;
  logic        data_exception;
  logic        data_inputRDY;
  logic        data_resultRDY;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef MULTDIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  multdiv_param #(.WIDTH_A(32), .WIDTH_B(16)) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_signed    (ctrl_signed),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_inputRDY  (data_inputRDY),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rem_exp(input logic [15:0] r);
    return REM_EN ? r : 16'h0000;
  endfunction

  // Called just after an active edge; the next edge accepts the request.
  task automatic do_op(input string name, input logic mult, input logic div, input logic sgn,
                       input logic [31:0] a, input logic [15:0] b, input int exp_lat,
                       input logic [31:0] exp_res, input logic [15:0] exp_rem_v,
                       input logic exp_exc);
    int lat;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    ctrl_signed   = sgn;
    @(posedge clock);
    #1;
    // Scramble inputs: they must not influence the running operation
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    ctrl_signed   = ~sgn;
    data_operandA = 32'hDEADBEEF;
    data_operandB = 16'h5A5A;
    check_eq({name, ".busy"}, {63'd0, data_inputRDY}, 64'd0);
    check_eq({name, ".rdyclr"}, {63'd0, data_resultRDY}, 64'd0);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = k;
        break;
      end
    end
    check_eq({name, ".lat"}, 64'(lat), 64'(exp_lat));
    check_eq({name, ".res"}, {32'd0, data_result}, {32'd0, exp_res});
    check_eq({name, ".rem"}, {48'd0, data_remainder}, {48'd0, rem_exp(exp_rem_v)});
    check_eq({name, ".exc"}, {63'd0, data_exception}, {63'd0, exp_exc});
    check_eq({name, ".inrdy"}, {63'd0, data_inputRDY}, 64'd1);
  endtask

  initial begin
    ctrl_reset_n  = 1'b0;
    data_operandA = 32'h0;
    data_operandB = 16'h0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    ctrl_signed   = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_eq("rst.inrdy", {63'd0, data_inputRDY}, 64'd1);
    check_eq("rst.resrdy", {63'd0, data_resultRDY}, 64'd0);
    check_eq("rst.res", {32'd0, data_result}, 64'd0);
    check_eq("rst.rem", {48'd0, data_remainder}, 64'd0);
    check_eq("rst.exc", {63'd0, data_exception}, 64'd0);
    ctrl_reset_n = 1'b1;

    // name, mult, div, signed, A, B, latency, result, remainder, exception
    do_op("smul_1000x-3", 1'b1, 1'b0, 1'b1, 32'd1000, 16'hFFFD, 8, 32'hFFFFF448, 16'h0000, 1'b0);
    do_op("sdiv_-7/2", 1'b0, 1'b1, 1'b1, 32'hFFFFFFF9, 16'd2, 33, 32'hFFFFFFFD, 16'hFFFF, 1'b0);
    do_op("div_5/0", 1'b0, 1'b1, 1'b0, 32'd5, 16'd0, 33, 32'h0, 16'h0000, 1'b1);
    do_op("smul_ovf", 1'b1, 1'b0, 1'b1, 32'h40000000, 16'd4, 8, 32'h00000000, 16'h0000, 1'b1);
    do_op("udiv_max", 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 33, 32'h00010001, 16'h0000, 1'b0);
    do_op("sdiv_min/-1", 1'b0, 1'b1, 1'b1, 32'h80000000, 16'hFFFF, 33, 32'h80000000, 16'h0000, 1'b1);
    do_op("both_hi", 1'b1, 1'b1, 1'b0, 32'd6, 16'd7, 8, 32'd42, 16'h0000, 1'b0);
    do_op("umul_max", 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 16'hFFFF, 8, 32'hFFFF0001, 16'h0000, 1'b1);
    do_op("umul_msb", 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 16'h8000, 8, 32'h7FFF8000, 16'h0000, 1'b0);
    do_op("smul_-1x-1", 1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 16'hFFFF, 8, 32'h00000001, 16'h0000, 1'b0);
    do_op("smul_maxpos", 1'b1, 1'b0, 1'b1, 32'h7FFFFFFF, 16'd1, 8, 32'h7FFFFFFF, 16'h0000, 1'b0);
    do_op("smul_2^31", 1'b1, 1'b0, 1'b1, 32'h40000000, 16'd2, 8, 32'h80000000, 16'h0000, 1'b1);
    do_op("umul_2^31", 1'b1, 1'b0, 1'b0, 32'h40000000, 16'd2, 8, 32'h80000000, 16'h0000, 1'b0);
    do_op("sdiv_7/-2", 1'b0, 1'b1, 1'b1, 32'd7, 16'hFFFE, 33, 32'hFFFFFFFD, 16'h0001, 1'b0);
    do_op("sdiv_-8/-3", 1'b0, 1'b1, 1'b1, 32'hFFFFFFF8, 16'hFFFD, 33, 32'h00000002, 16'hFFFE, 1'b0);
    do_op("udiv_100/7", 1'b0, 1'b1, 1'b0, 32'd100, 16'd7, 33, 32'd14, 16'h0002, 1'b0);

    // Result must hold in DONE while inputs wander and no request is made
    repeat (4) @(posedge clock);
    #1;
    check_eq("hold.res", {32'd0, data_result}, 64'd14);
    check_eq("hold.rdy", {63'd0, data_resultRDY}, 64'd1);

    // Reset at cycle 10 of a divide aborts it
    data_operandA = 32'd1000;
    data_operandB = 16'd3;
    ctrl_DIV      = 1'b1;
    ctrl_signed   = 1'b0;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    ctrl_reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_eq("abort.inrdy", {63'd0, data_inputRDY}, 64'd1);
    check_eq("abort.resrdy", {63'd0, data_resultRDY}, 64'd0);
    check_eq("abort.res", {32'd0, data_result}, 64'd0);
    check_eq("abort.rem", {48'd0, data_remainder}, 64'd0);
    check_eq("abort.exc", {63'd0, data_exception}, 64'd0);
    ctrl_reset_n = 1'b1;
    do_op("post_rst_7x6", 1'b1, 1'b0, 1'b0, 32'd7, 16'd6, 8, 32'd42, 16'h0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multdiv_param.md
MULTDIV_PARAM -- requirements
Module: multdiv_param

Interface
REQ-001 Parameter WIDTH_A, default 32: dividend/multiplicand and result width; SHALL be >= WIDTH_B.
REQ-002 Parameter WIDTH_B, default 16: divisor/multiplier and remainder width; SHALL be even and >= 4.
REQ-003 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 ctrl_reset_n  input  1  asynchronous, active-low reset.
REQ-005 data_operandA  input  WIDTH_A  operand A, sampled at accept.
REQ-006 data_operandB  input  WIDTH_B  operand B, sampled at accept.
REQ-007 ctrl_MULT  input  1  multiply request.
REQ-008 ctrl_DIV  input  1  divide request.
REQ-009 ctrl_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
REQ-010 data_result  output  WIDTH_A  product low bits or quotient.
REQ-011 data_remainder  output  WIDTH_B  division remainder.
REQ-012 data_exception  output  1  overflow or divide-by-zero flag for the held result.
REQ-013 data_inputRDY  output  1  unit can accept a request this cycle.
REQ-014 data_resultRDY  output  1  data_result/data_remainder/data_exception valid.

Function
REQ-015 FSM states SHALL be IDLE, MULT, DIV, DONE, with a cycle counter of ceil(log2(WIDTH_A+2)) bits.
REQ-016 data_inputRDY SHALL be 1 in IDLE and DONE, 0 in MULT and DIV.
REQ-017 Accept SHALL occur on a rising edge with data_inputRDY=1 and ctrl_MULT or ctrl_DIV high; operands and ctrl_signed are latched and the FSM enters MULT or DIV.
REQ-018 If ctrl_MULT and ctrl_DIV are both high at accept, MULT SHALL win.
REQ-019 Multiply SHALL use radix-4 Booth recoding: resultRDY rises exactly WIDTH_B/2 cycles after the accept edge (8 at defaults).
REQ-020 Divide SHALL use non-restoring or restoring iteration: resultRDY rises exactly WIDTH_A+1 cycles after the accept edge (33 at defaults), including divide-by-zero.
REQ-021 Upon completion the FSM SHALL enter DONE and hold resultRDY=1 and all result outputs stable until the next accept or reset.
REQ-022 Operand inputs SHALL be ignored outside the accept edge; changes mid-operation SHALL NOT affect the result.
REQ-023 An accept in DONE SHALL clear resultRDY on that edge (back-to-back operation, no idle cycle required).
REQ-024 Multiply result SHALL be the low WIDTH_A bits of the full WIDTH_A+WIDTH_B product; exception=1 iff the full product is not representable in WIDTH_A bits in the selected signedness.
REQ-025 Signed division SHALL truncate toward zero; the remainder sign follows the dividend; |remainder| < |divisor|.
REQ-026 Divisor 0 SHALL give exception=1, result=0, remainder=0.
REQ-027 Signed dividend = -2^(WIDTH_A-1) with divisor -1 SHALL give exception=1, result=-2^(WIDTH_A-1), remainder=0.
REQ-028 For multiply, data_remainder SHALL be 0.

Reset
REQ-029 ctrl_reset_n=0 SHALL, asynchronously, force IDLE, counter=0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, data_inputRDY=1.
REQ-030 Reset asserted mid-operation SHALL abort it; no resultRDY is produced for the aborted request.
REQ-031 After reset release, the first rising edge SHALL be able to accept a request.

Configuration
REQ-032 Macro MULTDIV_REMAINDER_EN: when defined, data_remainder follows REQ-025..REQ-028; when undefined, data_remainder SHALL be tied to 0, no remainder holding register is built, and quotient/exception behaviour and latency are unchanged.

Verification (defaults, MULTDIV_REMAINDER_EN defined)
REQ-033 Signed MULT 1000 x -3 -> result -3000, exception 0, resultRDY exactly 8 cycles after accept.
REQ-034 Signed DIV -7 / 2 -> result -3, remainder -1, exception 0, resultRDY exactly 33 cycles after accept.
REQ-035 DIV 5 / 0 -> exception 1, result 0, remainder 0, at cycle 33.
REQ-036 Signed MULT 0x40000000 x 4 -> result 0x00000000, exception 1; unsigned DIV 0xFFFFFFFF / 0xFFFF -> result 0x00010001, remainder 0.
REQ-037 Signed DIV 0x80000000 / -1 -> result 0x80000000, exception 1; MULT and DIV both high at accept -> multiply executes.
REQ-038 Reset at cycle 10 of a DIV -> next cycle inputRDY 1, resultRDY 0, outputs 0; a following MULT 7 x 6 -> 42 after 8 cycles.
